// File: rtl/imem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
package imem_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } imem_state_e;

    typedef struct packed {
        logic misalign;
        logic range;
    } fetch_fault_t;

    function automatic logic is_fault(input fetch_fault_t f);
        return f.misalign | f.range;
    endfunction

endpackage

// File: rtl/imem_bank.sv
// DEPTHx32 storage with one synchronous write port and a registered,
// enable-gated read port so the read data can hold during a stall.
module imem_bank #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_sync.sv
// IF-stage instruction memory: registered fetch with stall/flush, fault flags,
// run-time word loader and an optional NOP sweep after reset.
module imem_sync
    import imem_pkg::*;
#(
    parameter int          DEPTH         = 64,
    parameter bit          FILL_ON_RESET = 1'b1,
    parameter logic [31:0] NOP_WORD      = NOP_WORD_DEFAULT,
    localparam int         AW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    input  logic          stall,
    input  logic          flush,
    output logic [31:0]   instr_o,
    output logic          instr_valid,
    output logic          fault_misalign,
    output logic          fault_range,
    input  logic          ld_en,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          ready
);

    imem_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q;
    logic          valid_q, valid_d;
    fetch_fault_t  fault_q, fault_d;
    fetch_fault_t  fetch_fault;

    logic          bank_we;
    logic [AW-1:0] bank_waddr;
    logic [31:0]   bank_wdata;
    logic          bank_re;
    logic [31:0]   bank_rdata;

    imem_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (bank_re),
        .raddr (fetch_addr[AW+1:2]),
        .rdata (bank_rdata)
    );

    // Out-of-range words fault instead of aliasing onto the low words.
    always_comb begin
        fetch_fault.misalign = |fetch_addr[1:0];
        fetch_fault.range    = (fetch_addr[31:2] >= 30'(DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bank_we    = 1'b0;
        bank_waddr = ld_addr;
        bank_wdata = ld_data;
        case (state_q)
            INIT: begin
                bank_we    = 1'b1;
                bank_waddr = cnt_q;
                bank_wdata = NOP_WORD;
                cnt_d      = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ld_en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bank_we = ld_we;
                if (!ld_en) begin
                    state_d = RUN;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Storage is only written outside RUN, so reads never collide with writes.
    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        bank_re = 1'b0;
        if (state_q != RUN || flush) begin
            valid_d = 1'b0;
            fault_d = '0;
        end else if (!stall) begin
            if (fetch_req) begin
                fault_d = fetch_fault;
                valid_d = !is_fault(fetch_fault);
                bank_re = !is_fault(fetch_fault);
            end else begin
                valid_d = 1'b0;
                fault_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL_ON_RESET ? INIT : RUN;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RUN);
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign instr_o        = valid_q ? bank_rdata : NOP_WORD;
    assign instr_valid    = valid_q;
    assign fault_misalign = fault_q.misalign;
    assign fault_range    = fault_q.range;
    assign ready          = ready_q;

endmodule
